// File: rtl/context_state_table.sv
`default_nettype none
// ============================================================================
//  Module      : context_state_table
//  Description : Per-context probability state (Qe index + MPS) store with
//                sequential table initialisation, same-cycle write-back
//                bypass, context forwarding detection and a sticky error
//                flag for out-of-range contexts.
//  Revision    : 1.0  initial release
// ============================================================================
module context_state_table #(
    parameter int NUM_CX = 19,
    parameter int CXW    = 5,
    parameter int QEW    = 6,
    parameter int UNI_CX = 18,
    parameter int UNI_QE = 46,
    parameter int RL_CX  = 17,
    parameter int RL_QE  = 3,
    parameter int ZC_CX  = 0,
    parameter int ZC_QE  = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           init_req,
    input  logic           in_valid,
    input  logic           D,
    input  logic [CXW-1:0] CX,
    input  logic           flush_in,
    input  logic           upd_valid,
    input  logic [CXW-1:0] CX_update,
    input  logic           MPS_update,
    input  logic [QEW-1:0] QeIndex_update,
    output logic           ready,
    output logic           out_valid,
    output logic [QEW-1:0] QeIndex,
    output logic           MPS,
    output logic [CXW-1:0] CX_forward,
    output logic           D_forward,
    output logic           flush_out,
    output logic           Forwarding,
    output logic           cx_err
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [0:0]     ST_INIT    = 1'b0;
    localparam logic [0:0]     ST_RUN     = 1'b1;
    localparam logic [CXW:0]   c_num_cx   = NUM_CX[CXW:0];
    localparam logic [CXW-1:0] c_last_cnt = CXW'(NUM_CX - 1);

    // Initial Qe index of a context: three special contexts, all others 0.
    function automatic logic [QEW-1:0] default_qe(input logic [CXW-1:0] idx);
        logic [QEW-1:0] qe;
        qe = '0;
        if (idx == UNI_CX[CXW-1:0]) begin
            qe = UNI_QE[QEW-1:0];
        end else if (idx == RL_CX[CXW-1:0]) begin
            qe = RL_QE[QEW-1:0];
        end else if (idx == ZC_CX[CXW-1:0]) begin
            qe = ZC_QE[QEW-1:0];
        end
        return qe;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [0:0]     state_q, state_d;
    logic [CXW-1:0] cnt_q, cnt_d;

    logic [QEW-1:0] qe_tbl_q  [NUM_CX];
    logic [QEW-1:0] qe_tbl_d  [NUM_CX];
    logic           mps_tbl_q [NUM_CX];
    logic           mps_tbl_d [NUM_CX];

    logic           out_valid_q, out_valid_d;
    logic [QEW-1:0] qe_out_q, qe_out_d;
    logic           mps_out_q, mps_out_d;
    logic [CXW-1:0] cx_fwd_q, cx_fwd_d;
    logic           d_fwd_q, d_fwd_d;
    logic           flush_q, flush_d;
    logic           fwd_q, fwd_d;
    logic [CXW-1:0] last_cx_q, last_cx_d;
    logic           have_last_q, have_last_d;
    logic           cx_err_q, cx_err_d;

    logic w_ready;
    logic w_accept;
    logic w_upd;
    logic w_cx_ok;
    logic w_cxu_ok;

    // Control qualifiers: an init_req cycle neither accepts a symbol nor
    // commits a write-back, since the whole table is about to be rebuilt.
    always_comb begin
        w_accept = in_valid & w_ready & ~init_req;
        w_upd    = upd_valid & w_ready & ~init_req;
        w_cx_ok  = ({1'b0, CX} < c_num_cx);
        w_cxu_ok = ({1'b0, CX_update} < c_num_cx);
    end

    // FSM state register and clear counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM next state: INIT walks every entry once, then RUN until init_req.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (init_req) begin
            state_d = ST_INIT;
            cnt_d   = '0;
        end else if (state_q == ST_INIT) begin
            if (cnt_q == c_last_cnt) begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // FSM outputs: symbols are accepted only in RUN.
    always_comb begin
        w_ready = (state_q == ST_RUN);
    end

    // Table storage; contents are meaningless until INIT has completed.
    always_ff @(posedge clk) begin
        qe_tbl_q  <= qe_tbl_d;
        mps_tbl_q <= mps_tbl_d;
    end

    // Table next state: INIT clears one entry per cycle, RUN takes write-backs.
    always_comb begin
        qe_tbl_d  = qe_tbl_q;
        mps_tbl_d = mps_tbl_q;
        if (state_q == ST_INIT) begin
            qe_tbl_d[cnt_q]  = default_qe(cnt_q);
            mps_tbl_d[cnt_q] = 1'b0;
        end else if (w_upd && w_cxu_ok) begin
            qe_tbl_d[CX_update]  = QeIndex_update;
            mps_tbl_d[CX_update] = MPS_update;
        end
    end

    // Output and tracking registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            qe_out_q    <= '0;
            mps_out_q   <= 1'b0;
            cx_fwd_q    <= '0;
            d_fwd_q     <= 1'b0;
            flush_q     <= 1'b0;
            fwd_q       <= 1'b0;
            last_cx_q   <= '0;
            have_last_q <= 1'b0;
            cx_err_q    <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            qe_out_q    <= qe_out_d;
            mps_out_q   <= mps_out_d;
            cx_fwd_q    <= cx_fwd_d;
            d_fwd_q     <= d_fwd_d;
            flush_q     <= flush_d;
            fwd_q       <= fwd_d;
            last_cx_q   <= last_cx_d;
            have_last_q <= have_last_d;
            cx_err_q    <= cx_err_d;
        end
    end

    // Lookup path: bypass a same-cycle write-back, zero out bad contexts,
    // and flag a repeat of the previously accepted context.
    always_comb begin
        out_valid_d = w_accept;
        qe_out_d    = qe_out_q;
        mps_out_d   = mps_out_q;
        cx_fwd_d    = cx_fwd_q;
        d_fwd_d     = d_fwd_q;
        flush_d     = flush_q;
        fwd_d       = fwd_q;
        last_cx_d   = last_cx_q;
        have_last_d = have_last_q;
        cx_err_d    = cx_err_q | (w_accept & ~w_cx_ok) | (w_upd & ~w_cxu_ok);

        // Forwarding history restarts with every table (re)initialisation.
        if (init_req || (state_q == ST_INIT)) begin
            have_last_d = 1'b0;
        end

        if (w_accept) begin
            cx_fwd_d    = CX;
            d_fwd_d     = D;
            flush_d     = flush_in;
            fwd_d       = have_last_q & (CX == last_cx_q);
            last_cx_d   = CX;
            have_last_d = 1'b1;
            if (!w_cx_ok) begin
                qe_out_d  = '0;
                mps_out_d = 1'b0;
            end else if (upd_valid && (CX_update == CX)) begin
                qe_out_d  = QeIndex_update;
                mps_out_d = MPS_update;
            end else begin
                qe_out_d  = qe_tbl_q[CX];
                mps_out_d = mps_tbl_q[CX];
            end
        end
    end

    assign ready      = w_ready;
    assign out_valid  = out_valid_q;
    assign QeIndex    = qe_out_q;
    assign MPS        = mps_out_q;
    assign CX_forward = cx_fwd_q;
    assign D_forward  = d_fwd_q;
    assign flush_out  = flush_q;
    assign Forwarding = fwd_q;
    assign cx_err     = cx_err_q;

endmodule
`default_nettype wire

// File: tb/tb_context_state_table.sv
`default_nettype none
// ============================================================================
//  Module      : tb_context_state_table
//  Description : Scoreboard bench for context_state_table with a behavioural
//                reference table model, directed scenarios and random traffic.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_context_state_table;

    localparam int NUM_CX = 19;
    localparam int CXW    = 5;
    localparam int QEW    = 6;

    typedef struct packed {
        logic [QEW-1:0] qe;
        logic           mps;
        logic [CXW-1:0] cx;
        logic           d;
        logic           fl;
        logic           fwd;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           init_req = 1'b0;
    logic           in_valid = 1'b0;
    logic           D = 1'b0;
    logic [CXW-1:0] CX = '0;
    logic           flush_in = 1'b0;
    logic           upd_valid = 1'b0;
    logic [CXW-1:0] CX_update = '0;
    logic           MPS_update = 1'b0;
    logic [QEW-1:0] QeIndex_update = '0;
    logic           ready;
    logic           out_valid;
    logic [QEW-1:0] QeIndex;
    logic           MPS;
    logic [CXW-1:0] CX_forward;
    logic           D_forward;
    logic           flush_out;
    logic           Forwarding;
    logic           cx_err;

    context_state_table dut (
        .clk(clk), .rst(rst), .init_req(init_req), .in_valid(in_valid),
        .D(D), .CX(CX), .flush_in(flush_in), .upd_valid(upd_valid),
        .CX_update(CX_update), .MPS_update(MPS_update),
        .QeIndex_update(QeIndex_update), .ready(ready), .out_valid(out_valid),
        .QeIndex(QeIndex), .MPS(MPS), .CX_forward(CX_forward),
        .D_forward(D_forward), .flush_out(flush_out),
        .Forwarding(Forwarding), .cx_err(cx_err)
    );

    always #5 clk = ~clk;

    // Reference model state
    int          n_cmp = 0;
    int          n_bad = 0;
    exp_t        exp_q[$];
    exp_t        last_e = '0;
    int          m_qe  [NUM_CX];
    int          m_mps [NUM_CX];
    int          init_left;
    bit          m_err;
    bit          have_last;
    int          last_cx;

    function automatic int def_qe(input int i);
        if (i == 18) return 46;
        if (i == 17) return 3;
        if (i == 0)  return 4;
        return 0;
    endfunction

    task automatic model_init();
        for (int i = 0; i < NUM_CX; i++) begin
            m_qe[i]  = def_qe(i);
            m_mps[i] = 0;
        end
        init_left = NUM_CX;
        have_last = 1'b0;
    endtask

    task automatic cmp_out(input exp_t e, input string nm);
        n_cmp++;
        if ({QeIndex, MPS, CX_forward, D_forward, flush_out, Forwarding} !== e) begin
            n_bad++;
            $display("FAIL %s: got qe=%0d mps=%0b cx=%0d d=%0b fl=%0b fwd=%0b, want qe=%0d mps=%0b cx=%0d d=%0b fl=%0b fwd=%0b",
                     nm, QeIndex, MPS, CX_forward, D_forward, flush_out, Forwarding,
                     e.qe, e.mps, e.cx, e.d, e.fl, e.fwd);
        end
    endtask

    // Monitor: pops one expectation per out_valid, otherwise outputs must hold.
    always @(negedge clk) begin
        if (rst) begin
            last_e = '0;
        end else if (out_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL spurious_out_valid: got out_valid=1 cx=%0d, want no output", CX_forward);
            end else begin
                last_e = exp_q.pop_front();
                cmp_out(last_e, "symbol");
            end
        end else begin
            cmp_out(last_e, "hold");
        end
    end

    // One clock of stimulus; status is checked first, then inputs applied and
    // the model advanced, then the edge is taken.
    task automatic step(input bit inv, input bit d, input int cx, input bit fl,
                        input bit uv, input int cxu, input bit mu, input int qu,
                        input bit ini);
        exp_t e;
        bit   rdy;
        rdy = (init_left == 0);
        n_cmp++;
        if (ready !== rdy || cx_err !== m_err) begin
            n_bad++;
            $display("FAIL status: got ready=%0b cx_err=%0b, want ready=%0b cx_err=%0b",
                     ready, cx_err, rdy, m_err);
        end
        in_valid       = inv;
        D              = d;
        CX             = cx[CXW-1:0];
        flush_in       = fl;
        upd_valid      = uv;
        CX_update      = cxu[CXW-1:0];
        MPS_update     = mu;
        QeIndex_update = qu[QEW-1:0];
        init_req       = ini;

        if (ini) begin
            model_init();
        end else if (rdy) begin
            if (inv) begin
                e.cx  = cx[CXW-1:0];
                e.d   = d;
                e.fl  = fl;
                e.fwd = have_last && (cx == last_cx);
                if (cx >= NUM_CX) begin
                    e.qe  = '0;
                    e.mps = 1'b0;
                    m_err = 1'b1;
                end else if (uv && cxu == cx) begin
                    e.qe  = qu[QEW-1:0];
                    e.mps = mu;
                end else begin
                    e.qe  = m_qe[cx][QEW-1:0];
                    e.mps = m_mps[cx][0];
                end
                exp_q.push_back(e);
                have_last = 1'b1;
                last_cx   = cx;
            end
            if (uv) begin
                if (cxu >= NUM_CX) m_err = 1'b1;
                else begin
                    m_qe[cxu]  = qu;
                    m_mps[cxu] = mu;
                end
            end
        end else begin
            init_left--;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic sym(input int cx, input bit d, input bit fl);
        step(1, d, cx, fl, 0, 0, 0, 0, 0);
    endtask

    task automatic upd(input int cxu, input int qu, input bit mu);
        step(0, 0, 0, 0, 1, cxu, mu, qu, 0);
    endtask

    task automatic do_reset(input int hold);
        rst = 1'b1;
        in_valid = 0; upd_valid = 0; init_req = 0;
        #1;
        n_cmp++;
        if ({out_valid, QeIndex, MPS, CX_forward, D_forward, flush_out, Forwarding, cx_err, ready} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got ov=%0b qe=%0d mps=%0b cx=%0d d=%0b fl=%0b fwd=%0b err=%0b rdy=%0b, want all 0",
                     out_valid, QeIndex, MPS, CX_forward, D_forward, flush_out, Forwarding, cx_err, ready);
        end
        repeat (hold) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        m_err = 1'b0;
        model_init();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, want finish");
        $fatal(1);
    end

    initial begin
        int cx;
        int prev_cx;
        @(posedge clk);
        do_reset(2);

        // INIT with in_valid held high, then the special defaults
        repeat (NUM_CX) sym($urandom_range(0, 18), 1, 0);
        sym(18, 0, 0);
        sym(17, 1, 0);
        sym(0, 0, 1);
        sym(5, 1, 0);

        // Same-cycle write-back bypass, then stored read
        step(1, 0, 5, 0, 1, 5, 1, 12, 0);
        idle();
        sym(5, 0, 0);

        // Forwarding: 7,7,3 back to back, then 7, gap, 7
        sym(7, 0, 0);
        sym(7, 1, 0);
        sym(3, 0, 0);
        sym(7, 0, 0);
        idle();
        sym(7, 1, 0);

        // Write CX=18, re-initialise, in_valid during INIT, read back default
        upd(18, 20, 1);
        sym(18, 0, 0);
        step(1, 0, 4, 0, 0, 0, 0, 0, 1);
        repeat (NUM_CX) step(1, 1, 18, 0, 1, 18, 1, 33, 0);
        sym(18, 0, 0);

        // Out-of-range context: zero lookup, sticky error through init_req
        sym(25, 1, 0);
        upd(30, 7, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        repeat (NUM_CX) idle();
        sym(3, 0, 0);
        idle();

        // Reset during INIT cycle 10, then a full INIT and defaults
        do_reset(1);
        repeat (10) idle();
        do_reset(2);
        repeat (NUM_CX) idle();
        sym(18, 0, 0);
        sym(17, 0, 0);
        sym(0, 0, 0);
        sym(9, 0, 0);

        // Random traffic against the model
        prev_cx = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0) cx = prev_cx;
            else if ($urandom_range(0, 15) == 0) cx = $urandom_range(19, 31);
            else cx = $urandom_range(0, 18);
            prev_cx = cx;
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1), cx,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 1),
                 ($urandom_range(0, 1) != 0) ? cx : $urandom_range(0, 20),
                 $urandom_range(0, 1), $urandom_range(0, 63),
                 $urandom_range(0, 149) == 0);
        end
        repeat (3) idle();

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending outputs, want 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/context_state_table.md
CONTEXT_STATE_TABLE -- requirements
Module: context_state_table

Interface
REQ-001 Parameter NUM_CX, default 19: number of context entries, valid range 2..32.
REQ-002 Parameter CXW, default 5: context index width; SHALL satisfy 2^CXW >= NUM_CX.
REQ-003 Parameter QEW, default 6: Qe-table index width.
REQ-004 Parameters UNI_CX / UNI_QE, defaults 18 / 46; RL_CX / RL_QE, defaults 17 / 3; ZC_CX / ZC_QE, defaults 0 / 4: special initial states; all other contexts initialise to index 0; every context initialises with MPS 0.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 init_req  in  1  one-cycle pulse; re-initialises the whole table.
REQ-008 in_valid  in  1  symbol present on D/CX this cycle.
REQ-009 D  in  1  decision bit.
REQ-010 CX  in  CXW  context of the symbol.
REQ-011 flush_in  in  1  end-of-codeblock marker, travels with the symbol slot.
REQ-012 upd_valid  in  1  write-back from the coder is valid.
REQ-013 CX_update  in  CXW  context being written back.
REQ-014 MPS_update  in  1  new MPS value.
REQ-015 QeIndex_update  in  QEW  new Qe index.
REQ-016 ready  out  1  high when symbols are accepted (RUN state).
REQ-017 out_valid  out  1  output slot valid.
REQ-018 QeIndex  out  QEW  Qe index for CX_forward.
REQ-019 MPS  out  1  MPS for CX_forward.
REQ-020 CX_forward / D_forward / flush_out  out  CXW / 1 / 1  registered copies of CX, D and flush_in.
REQ-021 Forwarding  out  1  high when the output context equals the previous valid output context.
REQ-022 cx_err  out  1  sticky flag: an out-of-range context was accepted.

Function
REQ-023 FSM states: INIT and RUN; reset and init_req enter INIT with the clear counter at 0.
REQ-024 INIT: writes entry[cnt] = {default QE, MPS 0}, cnt increments by 1 per cycle, and on cnt = NUM_CX-1 the FSM moves to RUN on the next edge; INIT lasts exactly NUM_CX cycles.
REQ-025 ready = 1 only in RUN; in_valid while ready = 0 is ignored; upd_valid in INIT is ignored.
REQ-026 init_req in RUN: the symbol presented in the same cycle is dropped, and INIT restarts; init_req in INIT restarts cnt at 0.
REQ-027 Symbol accepted (in_valid & ready): after 1 cycle out_valid = 1, and CX_forward, D_forward, flush_out are captured.
REQ-028 Otherwise out_valid = 0 and all other outputs hold their values.
REQ-029 Lookup with upd_valid & CX_update == CX in the same cycle: QeIndex/MPS SHALL take QeIndex_update/MPS_update (bypass).
REQ-030 Otherwise QeIndex/MPS SHALL take the stored entry[CX].
REQ-031 upd_valid & ready: entry[CX_update] is written on the same edge, and a same-cycle read of that context uses the bypass value.
REQ-032 Forwarding = 1 iff the accepted CX equals the CX of the last accepted symbol; the first symbol after reset or INIT gives Forwarding = 0.
REQ-033 CX >= NUM_CX when accepted: QeIndex = 0, MPS = 0, cx_err is set, and no table entry changes.
REQ-034 CX_update >= NUM_CX: the write is discarded and cx_err is set.
REQ-035 cx_err clears only on rst.
REQ-036 flush_out propagates with no table side effect; a flush SHALL NOT clear the table (clearing is done by init_req).

Reset
REQ-037 rst asserted: QeIndex = 0, MPS = 0, CX_forward = 0, D_forward = 0, Forwarding = 0, out_valid = 0, flush_out = 0, cx_err = 0, ready = 0, FSM = INIT, cnt = 0.
REQ-038 Table contents are undefined during rst and are valid after INIT completes.
REQ-039 rst asserted mid-INIT or mid-RUN aborts immediately, and INIT restarts after rst is released.

Verification
REQ-040 Release rst, hold in_valid -> ready rises after 19 cycles; then CX=18, 17, 0, 5 give QeIndex 46, 3, 4, 0, each with MPS 0 and Forwarding 0.
REQ-041 upd_valid with CX_update=5, QE=12, MPS=1 in the same cycle as in_valid with CX=5 -> next cycle QeIndex=12, MPS=1; a later read of CX=5 also returns 12/1.
REQ-042 Back-to-back CX=7, 7, 3 -> Forwarding 0, 1, 0; a gap cycle with in_valid=0 between the two CX=7 symbols still gives Forwarding=1 on the second.
REQ-043 Write CX=18 with QE=20, then pulse init_req -> ready=0 for 19 cycles; afterwards CX=18 reads 46, and in_valid during INIT produces no out_valid.
REQ-044 CX=25 accepted -> QeIndex=0, MPS=0, cx_err=1; cx_err stays 1 through a later init_req and clears only on rst.
REQ-045 Assert rst during cycle 10 of INIT, release it -> all outputs at reset values, then a full 19-cycle INIT and correct defaults.
